ped_walk_panel: RTL and testbench
=================================

// Module: ped_walk_panel
// PURPOSE
//  Pedestrian-side end of the walk-request interface of the traffic light controller.
//  Debounces four crossing push-buttons and holds the controller's walk requests wlk[3:0].
//  Detects the controller's all-red pedestrian phase from its lamp outputs.
//  Drives the WALK / flashing DONT_WALK / solid DONT_WALK pedestrian lamps, plus a countdown.
// PARAMETERS
//  DEB_CYC    4  consecutive stable cycles before a button level is accepted
//  WALK_CYC   3  cycles the WALK lamp stays lit after entering the all-red phase
//  FLASH_CYC  2  cycles of flashing DONT_WALK after WALK
//  CNT_W      8  width of deb counters and walk_cnt; must hold max(DEB_CYC,WALK_CYC+FLASH_CYC)
// PORTS
//  clk       in   1      system clock; all logic on posedge clk
//  rst       in   1      synchronous, active-high reset
//  btn       in   4      raw pedestrian buttons, active-high, may bounce
//  main_R    in   1      controller main-road red lamp
//  side_R    in   1      controller side-road red lamp
//  w_s       in   1      controller walk-pending flag (request accepted)
//  wlk       out  4      walk requests to controller (wlk[0]..wlk[3] -> wlk1..wlk4), level
//  ped_walk  out  1      WALK lamp
//  ped_dont  out  1      DONT_WALK lamp (solid or flashing)
//  wait_lmp  out  1      "request registered" lamp
//  walk_cnt  out  CNT_W  cycles left in WALK+CLEAR; 0 otherwise
//  abort     out  1      one-cycle pulse: all-red ended while pedestrians had a signal
// BEHAVIOUR
//  Reset (rst=1 at posedge): state IDLE; wlk=0, ped_walk=0, ped_dont=1, wait_lmp=0,
//   walk_cnt=0, abort=0; debounce counters and deb levels 0; all_red_d=0.
//  Debounce, per button i: deb[i] takes the value btn[i] after btn[i] differs from deb[i] for DEB_CYC consecutive cycles.
//   Any mid-count bounce restarts that button's counter.
//   A rising edge of deb[i] sets wlk[i] on the next cycle.
//   Press-to-wlk latency is therefore DEB_CYC+1 cycles.
//  all_red = main_R & side_R; all_red_d is all_red delayed by one register.
//  all_red_rise = all_red & ~all_red_d.
//  FSM states: IDLE, WAIT, WALK, CLEAR (encoding in shared include).
//   IDLE : ped_dont=1. If any wlk bit is set -> WAIT.
//   WAIT : ped_dont=1. On all_red_rise -> WALK; clear all wlk bits in the same cycle (grant);
//          load walk_cnt = WALK_CYC+FLASH_CYC.
//          An all-red phase already in progress on entry is NOT used; wait for the next rise.
//   WALK : ped_walk=1, ped_dont=0; walk_cnt decrements each cycle.
//          When walk_cnt reaches FLASH_CYC -> CLEAR.
//   CLEAR: ped_walk=0; ped_dont toggles every cycle, starting at 1.
//          When walk_cnt reaches 0 -> IDLE if wlk==0, else WAIT.
//  Safety: if all_red=0 in WALK or CLEAR, go to IDLE in the same cycle.
//   That cycle: ped_walk=0, ped_dont=1, walk_cnt=0, abort=1 for one cycle.
//   Lamp outputs are registered, so the lamps follow all_red falling with exactly one cycle of latency.
//   The safe state is never delayed by a counter.
//  Buttons pressed during WALK/CLEAR: wlk bit sets normally and is held.
//   The request is served on the next all_red_rise; it is never granted mid-phase.
//  Grant and a new press of the same button in the same cycle: the clear wins.
//   The press is lost only when deb edge and grant coincide exactly.
//  wait_lmp = (|wlk) | w_s, registered.
//  ped_walk and ped_dont are never both 1.
//  All state-to-output relations above are registered: outputs reflect the state entered at that clock edge.
// STRUCTURE
//  Shared include tl_defs.vh holds:
//   - FSM state localparams IDLE=2'd0, WAIT=2'd1, WALK=2'd2, CLEAR=2'd3;
//   - the controller's all-red phase codes, reused by the controller.
//  Sub-module btn_debounce #(DEB_CYC,CNT_W) (clk, rst, raw, deb, rise), instantiated four times.
//  FSM, counters and output registers live in ped_walk_panel.
// TESTING
//  1 Bounce: btn[0] toggles 1,0,1 then held 1.
//    -> wlk[0]=1 exactly DEB_CYC+1 cycles after the last toggle; no earlier assertion.
//  2 Full cycle: wlk[2] set, then main_R=side_R=1 held 10 cycles.
//    -> wlk cleared at the rise; ped_walk high 3 cycles with walk_cnt 5,4,3.
//    -> ped_dont pattern 1,0 over 2 cycles; then IDLE with ped_dont=1.
//  3 Late request: press during an all-red phase already active.
//    -> stays WAIT with ped_dont=1 until all-red drops and rises again.
//  4 Abort: all-red drops on the 2nd WALK cycle.
//    -> next cycle ped_walk=0, ped_dont=1, walk_cnt=0, abort pulse width 1.
//  5 Requeue: btn[3] pressed during CLEAR.
//    -> wlk[3]=1 held; after CLEAR state is WAIT, not IDLE.
//  6 Reset mid-WALK: rst=1 for 1 cycle.
//    -> all outputs at reset values next cycle; wlk=0; debouncers cleared.

Source files
------------

// File: rtl/ped_walk_panel_pkg.sv
// Shared types for the pedestrian walk panel: panel FSM states and the
// controller's phase codes, which the traffic light controller also uses.
package ped_walk_panel_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        WALK  = 2'd2,
        CLEAR = 2'd3
    } ped_state_t;

    // Controller phase codes; the two all-red codes bracket each road's green.
    typedef enum logic [2:0] {
        PH_MAIN_GREEN  = 3'd0,
        PH_MAIN_YELLOW = 3'd1,
        PH_ALL_RED_A   = 3'd2,
        PH_SIDE_GREEN  = 3'd3,
        PH_SIDE_YELLOW = 3'd4,
        PH_ALL_RED_B   = 3'd5
    } ctrl_phase_t;

endpackage

// File: rtl/ped_walk_panel_debounce.sv
// Single push-button debouncer: accepts a new level only after it has been
// stable for DEB_CYC consecutive samples, and pulses rise on an accepted press.
module btn_debounce #(
    parameter int DEB_CYC = 4,
    parameter int CNT_W   = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic deb,
    output logic rise
);

    logic [CNT_W-1:0] cnt;
    logic             settle;

    assign settle = (raw != deb) && (cnt == CNT_W'(DEB_CYC - 1));

    // Any sample that agrees with the accepted level restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            deb  <= 1'b0;
            rise <= 1'b0;
        end else begin
            rise <= settle && raw;
            if (raw == deb) begin
                cnt <= '0;
            end else if (settle) begin
                cnt <= '0;
                deb <= raw;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ped_walk_panel.sv
// Pedestrian side of the walk-request interface: holds debounced walk requests
// and drives the WALK / DONT_WALK lamps from the controller's all-red phase.
module ped_walk_panel
    import ped_walk_panel_pkg::*;
#(
    parameter int DEB_CYC   = 4,
    parameter int WALK_CYC  = 3,
    parameter int FLASH_CYC = 2,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       btn,
    input  logic             main_R,
    input  logic             side_R,
    input  logic             w_s,
    output logic [3:0]       wlk,
    output logic             ped_walk,
    output logic             ped_dont,
    output logic             wait_lmp,
    output logic [CNT_W-1:0] walk_cnt,
    output logic             abort
);

    ped_state_t       state, state_n;
    logic [3:0]       rise;
    logic [3:0]       deb_unused;
    logic             all_red, all_red_d, all_red_rise;
    logic [3:0]       wlk_n;
    logic [CNT_W-1:0] cnt_n;
    logic             walk_n, dont_n, abort_n;

    for (genvar i = 0; i < 4; i++) begin : g_deb
        btn_debounce #(
            .DEB_CYC(DEB_CYC),
            .CNT_W  (CNT_W)
        ) u_deb (
            .clk (clk),
            .rst (rst),
            .raw (btn[i]),
            .deb (deb_unused[i]),
            .rise(rise[i])
        );
    end

    assign all_red      = main_R & side_R;
    assign all_red_rise = all_red & ~all_red_d;

    // Lamps and counter are computed for the state being entered, then registered.
    always_comb begin
        state_n = state;
        wlk_n   = wlk | rise;
        cnt_n   = walk_cnt;
        walk_n  = 1'b0;
        dont_n  = 1'b1;
        abort_n = 1'b0;
        case (state)
            IDLE: begin
                if (|wlk) state_n = WAIT;
            end
            WAIT: begin
                if (all_red_rise) begin
                    state_n = WALK;
                    wlk_n   = '0;
                    cnt_n   = CNT_W'(WALK_CYC + FLASH_CYC);
                    walk_n  = 1'b1;
                    dont_n  = 1'b0;
                end
            end
            WALK: begin
                if (!all_red) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    abort_n = 1'b1;
                end else begin
                    cnt_n = walk_cnt - 1'b1;
                    if (cnt_n == CNT_W'(FLASH_CYC)) begin
                        state_n = CLEAR;
                    end else begin
                        walk_n = 1'b1;
                        dont_n = 1'b0;
                    end
                end
            end
            CLEAR: begin
                if (!all_red) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    abort_n = 1'b1;
                end else begin
                    cnt_n = walk_cnt - 1'b1;
                    if (cnt_n == '0) begin
                        state_n = (|wlk) ? WAIT : IDLE;
                    end else begin
                        dont_n = ~ped_dont;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wlk       <= '0;
            ped_walk  <= 1'b0;
            ped_dont  <= 1'b1;
            wait_lmp  <= 1'b0;
            walk_cnt  <= '0;
            abort     <= 1'b0;
            all_red_d <= 1'b0;
        end else begin
            state     <= state_n;
            wlk       <= wlk_n;
            ped_walk  <= walk_n;
            ped_dont  <= dont_n;
            wait_lmp  <= (|wlk) | w_s;
            walk_cnt  <= cnt_n;
            abort     <= abort_n;
            all_red_d <= all_red;
        end
    end

endmodule

// File: tb/tb_ped_walk_panel.sv
// Self-checking bench for ped_walk_panel: directed scenarios plus random
// buttons and lamp phases, compared every cycle against a timer-based model.
module tb_ped_walk_panel;

    localparam int DEB   = 4;
    localparam int WALKC = 3;
    localparam int FLASH = 2;
    localparam int CW    = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    btn;
    logic          main_r, side_r, w_s;
    logic [3:0]    wlk;
    logic          ped_walk, ped_dont, wait_lmp, abort;
    logic [CW-1:0] walk_cnt;

    always #5 clk = ~clk;

    ped_walk_panel #(
        .DEB_CYC  (DEB),
        .WALK_CYC (WALKC),
        .FLASH_CYC(FLASH),
        .CNT_W    (CW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btn     (btn),
        .main_R  (main_r),
        .side_R  (side_r),
        .w_s     (w_s),
        .wlk     (wlk),
        .ped_walk(ped_walk),
        .ped_dont(ped_dont),
        .wait_lmp(wait_lmp),
        .walk_cnt(walk_cnt),
        .abort   (abort)
    );

    int checks = 0;
    int errors = 0;

    // Model: accepted button levels, outstanding requests, and the number of
    // cycles left in the pedestrian phase (0 when no phase is running).
    bit [3:0] m_lvl;
    int       m_run [4];
    bit [3:0] m_rise;
    bit [3:0] m_req;
    int       m_left;
    bit       m_waiting;
    bit       m_prev_red;
    bit       e_abort;
    bit       e_wait_lmp;

    logic [3:0] cur_btn;
    logic       cur_m, cur_s, cur_ws;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_lvl      = '0;
        m_rise     = '0;
        m_req      = '0;
        m_left     = 0;
        m_waiting  = 1'b0;
        m_prev_red = 1'b0;
        e_abort    = 1'b0;
        e_wait_lmp = 1'b0;
        for (int i = 0; i < 4; i++) m_run[i] = 0;
    endtask

    task automatic model_clock(input bit r, input logic [3:0] b, input bit mr, input bit sr, input bit ws);
        bit       red, red_rise, grant;
        bit [3:0] new_rise;
        if (r) begin
            model_reset();
            return;
        end
        red      = mr & sr;
        red_rise = red & !m_prev_red;
        new_rise = '0;
        for (int i = 0; i < 4; i++) begin
            if (b[i] != m_lvl[i]) begin
                m_run[i]++;
                if (m_run[i] == DEB) begin
                    m_lvl[i]    = b[i];
                    m_run[i]    = 0;
                    new_rise[i] = b[i];
                end
            end else begin
                m_run[i] = 0;
            end
        end
        grant      = 1'b0;
        e_abort    = 1'b0;
        e_wait_lmp = (m_req != 0) | ws;
        if (m_left > 0) begin
            if (!red) begin
                e_abort   = 1'b1;
                m_left    = 0;
                m_waiting = 1'b0;
            end else begin
                m_left--;
                if (m_left == 0) m_waiting = (m_req != 0);
            end
        end else if (m_waiting) begin
            if (red_rise) begin
                grant     = 1'b1;
                m_left    = WALKC + FLASH;
                m_waiting = 1'b0;
            end
        end else if (m_req != 0) begin
            m_waiting = 1'b1;
        end
        m_req      = grant ? 4'b0 : (m_req | m_rise);
        m_rise     = new_rise;
        m_prev_red = red;
    endtask

    task automatic applyStimulus(input bit r, input logic [3:0] b, input bit mr, input bit sr, input bit ws);
        bit e_walk, e_dont;
        rst    = r;
        btn    = b;
        main_r = mr;
        side_r = sr;
        w_s    = ws;
        @(posedge clk);
        model_clock(r, b, mr, sr, ws);
        #1;
        e_walk = (m_left > FLASH);
        if (m_left == 0)        e_dont = 1'b1;
        else if (m_left > FLASH) e_dont = 1'b0;
        else                     e_dont = ((FLASH - m_left) % 2 == 0);
        checkOutput("wlk", wlk, m_req);
        checkOutput("ped_walk", ped_walk, e_walk);
        checkOutput("ped_dont", ped_dont, e_dont);
        checkOutput("walk_cnt", walk_cnt, m_left);
        checkOutput("abort", abort, e_abort);
        checkOutput("wait_lmp", wait_lmp, e_wait_lmp);
        checkOutput("lamp_excl", ped_walk & ped_dont, 1'b0);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, cur_btn, cur_m, cur_s, cur_ws);
    endtask

    task automatic set_red(input bit v);
        cur_m = v;
        cur_s = v;
    endtask

    initial begin
        int lat;
        int seg;
        model_reset();
        cur_btn = '0;
        cur_ws  = 1'b0;
        set_red(1'b0);
        applyStimulus(1'b1, cur_btn, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, cur_btn, 1'b0, 1'b0, 1'b0);
        checkOutput("reset_dont", ped_dont, 1'b1);
        checkOutput("reset_wlk", wlk, 4'b0);
        run(2);

        $display("[TB] bounce on btn0");
        cur_btn = 4'b0001; run(1);
        cur_btn = 4'b0000; run(1);
        cur_btn = 4'b0001;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            run(1);
            if (wlk[0] && lat == 0) lat = k;
        end
        checkOutput("press_latency", lat, DEB + 1);
        cur_btn = 4'b0000; run(6);

        $display("[TB] full walk cycle on btn2");
        cur_btn = 4'b0100; run(7);
        cur_btn = 4'b0000; run(2);
        set_red(1'b1); run(10);
        set_red(1'b0); run(3);

        $display("[TB] late request during all-red");
        set_red(1'b1); run(2);
        cur_btn = 4'b0010; run(6);
        cur_btn = 4'b0000; run(4);
        checkOutput("late_no_walk", ped_walk, 1'b0);
        set_red(1'b0); run(2);
        set_red(1'b1); run(8);
        set_red(1'b0); run(2);

        $display("[TB] abort on second walk cycle");
        cur_btn = 4'b1000; run(6);
        cur_btn = 4'b0000; run(1);
        set_red(1'b1); run(2);
        set_red(1'b0); run(1);
        checkOutput("abort_pulse", abort, 1'b1);
        run(1);
        checkOutput("abort_width", abort, 1'b0);
        run(2);

        $display("[TB] requeue during phase");
        cur_btn = 4'b0001; run(6);
        cur_btn = 4'b0000; run(1);
        set_red(1'b1);
        cur_btn = 4'b1000; run(8);
        cur_btn = 4'b0000; run(3);
        set_red(1'b0); run(2);
        set_red(1'b1); run(7);
        set_red(1'b0); run(2);

        $display("[TB] reset mid-walk");
        cur_btn = 4'b0100; run(6);
        set_red(1'b1); run(2);
        applyStimulus(1'b1, cur_btn, cur_m, cur_s, cur_ws);
        checkOutput("rst_mid_walk", ped_walk, 1'b0);
        run(3);
        cur_btn = 4'b0000; set_red(1'b0); run(6);

        $display("[TB] random traffic");
        seg = 0;
        for (int n = 0; n < 1500; n++) begin
            if (seg == 0) begin
                seg = $urandom_range(2, 12);
                case ($urandom % 4)
                    0, 1: begin cur_m = 1'b1; cur_s = 1'b1; end
                    2:    begin cur_m = 1'b1; cur_s = 1'b0; end
                    default: begin cur_m = 1'b0; cur_s = 1'b1; end
                endcase
            end
            seg--;
            for (int i = 0; i < 4; i++)
                if ($urandom % 10 == 0) cur_btn[i] = ~cur_btn[i];
            cur_ws = ($urandom % 4 == 0);
            applyStimulus(($urandom % 250) == 0, cur_btn, cur_m, cur_s, cur_ws);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
